mips_load_unit: RTL and testbench

Data-memory load engine for the MIPS core: the read-side counterpart of the store byte-enable generator. Given a load type, byte address and the current `rt` value, it issues one word-aligned Avalon-MM read with the correct byte enables, waits out `waitrequest`, then extracts, sign/zero-extends or merges the returned bytes into a 32-bit register result. It sits between the execute stage and the data bus and stalls the core via `busy` until `done`.

---
 rtl/mips_load_pkg.sv | 27 ++
 rtl/mips_load_align.sv | 82 ++++++++
 rtl/mips_load_unit.sv | 117 +++++++++++
 tb/tb_mips_load_unit.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_load_pkg.sv
// Shared types and constants for the MIPS data-memory load engine.
package mips_load_pkg;

    typedef enum logic [2:0] {
        LT_LB      = 3'd0,
        LT_LBU     = 3'd1,
        LT_LH      = 3'd2,
        LT_LHU     = 3'd3,
        LT_LW      = 3'd4,
        LT_LWL     = 3'd5,
        LT_LWR     = 3'd6,
        LT_INVALID = 3'd7
    } load_type_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } load_state_t;

    localparam logic [3:0] BE_NONE  = 4'b0000;
    localparam logic [3:0] BE_BYTE0 = 4'b0001;
    localparam logic [3:0] BE_LO    = 4'b0011;
    localparam logic [3:0] BE_HI    = 4'b1100;
    localparam logic [3:0] BE_ALL   = 4'b1111;

endpackage

// File: rtl/mips_load_align.sv
// Byte-enable generation, legality check and extract/extend/merge of read data.
// LWL/LWR merge logic exists only when MIPS_LOAD_LWLR_EN is defined.
module mips_load_align
    import mips_load_pkg::*;
(
    input  logic [2:0]  load_type,
    input  logic [1:0]  k,
    input  logic [31:0] rt_old,
    input  logic [31:0] rd,
    output logic        legal,
    output logic [3:0]  byteenable,
    output logic [31:0] result
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign lane_b = rd[{k, 3'b000} +: 8];
    assign lane_h = k[1] ? rd[31:16] : rd[15:0];

`ifdef MIPS_LOAD_LWLR_EN
    logic [4:0] sh_l;
    logic [4:0] sh_r;

    assign sh_l = {2'd3 - k, 3'b000};
    assign sh_r = {k, 3'b000};
`endif

    always_comb begin
        legal      = 1'b0;
        byteenable = BE_NONE;
        result     = rt_old;
        unique case (load_type_t'(load_type))
            LT_LB: begin
                legal      = 1'b1;
                byteenable = BE_BYTE0 << k;
                result     = {{24{lane_b[7]}}, lane_b};
            end
            LT_LBU: begin
                legal      = 1'b1;
                byteenable = BE_BYTE0 << k;
                result     = {24'd0, lane_b};
            end
            LT_LH: begin
                legal      = ~k[0];
                byteenable = k[1] ? BE_HI : BE_LO;
                result     = {{16{lane_h[15]}}, lane_h};
            end
            LT_LHU: begin
                legal      = ~k[0];
                byteenable = k[1] ? BE_HI : BE_LO;
                result     = {16'd0, lane_h};
            end
            LT_LW: begin
                legal      = (k == 2'd0);
                byteenable = BE_ALL;
                result     = rd;
            end
`ifdef MIPS_LOAD_LWLR_EN
            LT_LWL: begin
                legal      = 1'b1;
                byteenable = BE_ALL >> (2'd3 - k);
                result     = (rd << sh_l)
                           | (rt_old & ~(32'hFFFF_FFFF << sh_l));
            end
            LT_LWR: begin
                legal      = 1'b1;
                byteenable = BE_ALL << k;
                result     = (rd >> sh_r)
                           | (rt_old & ~(32'hFFFF_FFFF >> sh_r));
            end
`endif
            default: ;
        endcase
        // Illegal requests never touch the bus and pass rt through.
        if (!legal) begin
            byteenable = BE_NONE;
            result     = rt_old;
        end
    end

endmodule

// File: rtl/mips_load_unit.sv
// MIPS load engine: one Avalon-MM read per load, waitrequest timeout, busy/done.
// Optional LWL/LWR support via MIPS_LOAD_LWLR_EN.
module mips_load_unit
    import mips_load_pkg::*;
#(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  load_type,
    input  logic [31:0] addr,
    input  logic [31:0] rt_old,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] result,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic [3:0]  avm_byteenable,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest
);

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    load_state_t state;
    logic [7:0]  wait_cnt;
    logic [2:0]  type_q;
    logic [1:0]  k_q;
    logic [31:0] rt_q;

    logic        idle;
    logic [2:0]  sel_type;
    logic [1:0]  sel_k;
    logic [31:0] sel_rt;
    logic        legal;
    logic [3:0]  be_c;
    logic [31:0] res_c;

    // Decode the live request in IDLE, the captured one while the read is out.
    assign idle     = (state == ST_IDLE);
    assign sel_type = idle ? load_type : type_q;
    assign sel_k    = idle ? addr[1:0] : k_q;
    assign sel_rt   = idle ? rt_old : rt_q;

    assign busy = !idle;
    assign done = (state == ST_DONE);

    mips_load_align u_align (
        .load_type  (sel_type),
        .k          (sel_k),
        .rt_old     (sel_rt),
        .rd         (avm_readdata),
        .legal      (legal),
        .byteenable (be_c),
        .result     (res_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            wait_cnt       <= 8'd0;
            type_q         <= 3'd0;
            k_q            <= 2'd0;
            rt_q           <= 32'd0;
            err            <= 1'b0;
            result         <= 32'd0;
            avm_address    <= 32'd0;
            avm_read       <= 1'b0;
            avm_byteenable <= BE_NONE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        type_q <= load_type;
                        k_q    <= addr[1:0];
                        rt_q   <= rt_old;
                        if (legal) begin
                            state          <= ST_REQ;
                            wait_cnt       <= 8'd0;
                            avm_read       <= 1'b1;
                            avm_address    <= {addr[31:2], 2'b00};
                            avm_byteenable <= be_c;
                        end else begin
                            state  <= ST_DONE;
                            err    <= 1'b1;
                            result <= rt_old;
                        end
                    end
                end
                ST_REQ: begin
                    if (!avm_waitrequest) begin
                        state          <= ST_DONE;
                        err            <= 1'b0;
                        result         <= res_c;
                        avm_read       <= 1'b0;
                        avm_address    <= 32'd0;
                        avm_byteenable <= BE_NONE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state          <= ST_DONE;
                        err            <= 1'b1;
                        result         <= rt_q;
                        avm_read       <= 1'b0;
                        avm_address    <= 32'd0;
                        avm_byteenable <= BE_NONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_load_unit.sv
// Bench for mips_load_unit: byte-level load model, per-cycle compare, directed loads.
module tb_mips_load_unit;

    localparam int MW = 4;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  load_type;
    logic [31:0] addr;
    logic [31:0] rt_old;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] result;
    logic [31:0] avm_address;
    logic        avm_read;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    mips_load_unit #(.MAX_WAIT(MW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .load_type       (load_type),
        .addr            (addr),
        .rt_old          (rt_old),
        .busy            (busy),
        .done            (done),
        .err             (err),
        .result          (result),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_byteenable  (avm_byteenable),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest)
    );

    typedef struct {
        int          c0;
        int          done_cyc;
        logic        legal;
        logic        err;
        logic [3:0]  be;
        logic [31:0] adr;
        logic [31:0] res;
        logic [31:0] lit;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          pass_cnt = 0;
    int          total_cnt = 0;
    bit          chk_en = 0;
    int          nwait = 0;
    int          req_seen = 0;
    logic [31:0] rdata = 32'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Data is only trustworthy on the cycle waitrequest is low.
    assign avm_readdata = avm_waitrequest ? ~rdata : rdata;

    always @(negedge clk) begin
        if (avm_read) req_seen = req_seen + 1;
        avm_waitrequest = avm_read && (req_seen <= nwait);
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total_cnt = total_cnt + 1;
        if (act === exp) pass_cnt = pass_cnt + 1;
        else $display("FAIL %s actual=%h required=%h at cycle %0d",
                      name, act, exp, cyc);
    endtask

    function automatic void model(input int lt, input logic [31:0] a,
                                  input logic [31:0] rt, input logic [31:0] rd,
                                  output logic lg, output logic [3:0] be,
                                  output logic [31:0] res);
        logic [7:0] r[4];
        logic [7:0] o[4];
        int k;
        k = int'(a[1:0]);
        for (int i = 0; i < 4; i++) begin
            r[i] = rd[8*i +: 8];
            o[i] = rt[8*i +: 8];
        end
        lg  = 1'b0;
        be  = 4'b0000;
        res = rt;
        case (lt)
            0, 1: begin
                lg    = 1'b1;
                be[k] = 1'b1;
                res   = {24'd0, r[k]};
                if (lt == 0 && r[k][7]) res = res | 32'hFFFF_FF00;
            end
            2, 3: begin
                if (k == 0 || k == 2) begin
                    lg      = 1'b1;
                    be[k]   = 1'b1;
                    be[k+1] = 1'b1;
                    res     = {16'd0, r[k+1], r[k]};
                    if (lt == 2 && r[k+1][7]) res = res | 32'hFFFF_0000;
                end
            end
            4: begin
                if (k == 0) begin
                    lg  = 1'b1;
                    be  = 4'b1111;
                    res = rd;
                end
            end
`ifdef MIPS_LOAD_LWLR_EN
            5: begin
                lg = 1'b1;
                for (int i = 0; i <= k; i++) begin
                    o[3-k+i] = r[i];
                    be[i]    = 1'b1;
                end
                res = {o[3], o[2], o[1], o[0]};
            end
            6: begin
                lg = 1'b1;
                for (int i = 0; i <= 3 - k; i++) begin
                    o[i]    = r[k+i];
                    be[k+i] = 1'b1;
                end
                res = {o[3], o[2], o[1], o[0]};
            end
`endif
            default: ;
        endcase
        if (!lg) begin
            be  = 4'b0000;
            res = rt;
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        bit   act;
        bit   eb;
        bit   ed;
        bit   er;
        if (chk_en && rst_n) begin
            act = (q.size() > 0);
            if (act) e = q[0];
            eb = act && cyc > e.c0 && cyc <= e.done_cyc;
            ed = act && cyc == e.done_cyc;
            er = act && e.legal && cyc > e.c0 && cyc < e.done_cyc;
            check("busy", {31'd0, busy}, {31'd0, eb});
            check("done", {31'd0, done}, {31'd0, ed});
            check("avm_read", {31'd0, avm_read}, {31'd0, er});
            if (er && avm_read) begin
                check("avm_address", avm_address, e.adr);
                check("avm_byteenable", {28'd0, avm_byteenable}, {28'd0, e.be});
            end
            if (ed) begin
                check("err", {31'd0, err}, {31'd0, e.err});
                check("result", result, e.res);
                check("result_literal", result, e.lit);
                void'(q.pop_front());
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 40 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            check("load_completion_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
    endtask

    task automatic run_load(input int lt, input logic [31:0] a,
                            input logic [31:0] rt, input logic [31:0] rd,
                            input int nw, input logic [31:0] lit,
                            input bit poke);
        exp_t        e;
        logic        lg;
        logic [3:0]  be;
        logic [31:0] res;
        @(negedge clk);
        model(lt, a, rt, rd, lg, be, res);
        e.c0    = cyc;
        e.legal = lg;
        e.be    = be;
        e.adr   = {a[31:2], 2'b00};
        e.lit   = lit;
        if (!lg) begin
            e.done_cyc = cyc + 1;
            e.err      = 1'b1;
            e.res      = rt;
        end else if (nw >= MW) begin
            e.done_cyc = cyc + 1 + MW;
            e.err      = 1'b1;
            e.res      = rt;
        end else begin
            e.done_cyc = cyc + 2 + nw;
            e.err      = 1'b0;
            e.res      = res;
        end
        nwait     = nw;
        req_seen  = 0;
        rdata     = rd;
        start     = 1'b1;
        load_type = lt[2:0];
        addr      = a;
        rt_old    = rt;
        q.push_back(e);
        @(negedge clk);
        start     = 1'b0;
        load_type = 3'd7;
        addr      = 32'hFFFF_FFFF;
        rt_old    = 32'h0;
        if (poke) begin
            // Extra requests while busy and in the done cycle must be dropped.
            @(negedge clk);
            start     = 1'b1;
            load_type = 3'd0;
            addr      = 32'h0000_0040;
            @(negedge clk);
            start = 1'b0;
            while (cyc < e.done_cyc) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (3) @(negedge clk);
        end
        wait_idle();
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        load_type = 3'd0;
        addr      = 32'd0;
        rt_old    = 32'd0;
        repeat (2) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        check("reset_read", {31'd0, avm_read}, 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_address", avm_address, 32'd0);
        check("reset_byteenable", {28'd0, avm_byteenable}, 32'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        run_load(0, 32'h0000_1003, 32'h0, 32'h80AA_BBCC, 0, 32'hFFFF_FF80, 0);
        run_load(3, 32'h0000_2002, 32'h0, 32'h8001_FFFF, 3, 32'h0000_8001, 0);
`ifdef MIPS_LOAD_LWLR_EN
        run_load(5, 32'h0000_3001, 32'h1122_3344, 32'hAABB_CCDD, 0, 32'hCCDD_3344, 0);
        run_load(6, 32'h0000_3002, 32'h1122_3344, 32'hAABB_CCDD, 0, 32'h1122_AABB, 0);
        run_load(5, 32'h0000_3000, 32'h1122_3344, 32'hAABB_CCDD, 1, 32'hDD22_3344, 0);
        run_load(5, 32'h0000_3003, 32'h1122_3344, 32'hAABB_CCDD, 0, 32'hAABB_CCDD, 0);
        run_load(6, 32'h0000_3003, 32'h1122_3344, 32'hAABB_CCDD, 0, 32'h1122_33AA, 0);
`else
        run_load(5, 32'h0000_3001, 32'h1122_3344, 32'hAABB_CCDD, 0, 32'h1122_3344, 0);
        run_load(6, 32'h0000_3002, 32'h1122_3344, 32'hAABB_CCDD, 0, 32'h1122_3344, 0);
`endif
        run_load(4, 32'h0000_4002, 32'hCAFE_F00D, 32'h1234_5678, 0, 32'hCAFE_F00D, 0);
        run_load(2, 32'h0000_4001, 32'h0BAD_BEEF, 32'h1234_5678, 0, 32'h0BAD_BEEF, 0);
        run_load(7, 32'h0000_4000, 32'h0000_0077, 32'h1234_5678, 0, 32'h0000_0077, 0);
        run_load(2, 32'h0000_7000, 32'h0, 32'h1234_F00D, 0, 32'hFFFF_F00D, 0);
        run_load(4, 32'h0000_8000, 32'h0, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 0);
        run_load(0, 32'h0000_9000, 32'h0, 32'h0000_007F, 0, 32'h0000_007F, 0);
        run_load(0, 32'h0000_9002, 32'h0, 32'h0080_0000, 2, 32'hFFFF_FF80, 0);
        run_load(3, 32'h0000_9000, 32'h0, 32'h0000_ABCD, 0, 32'h0000_ABCD, 0);
        run_load(2, 32'h0000_9002, 32'h0, 32'h7FFF_0000, 0, 32'h0000_7FFF, 0);
        run_load(4, 32'h0000_5000, 32'h0000_0099, 32'h1111_1111, 10, 32'h0000_0099, 1);

        // Reset in the middle of an outstanding read.
        @(negedge clk);
        chk_en    = 1'b0;
        nwait     = 10;
        req_seen  = 0;
        rdata     = 32'h5555_AAAA;
        start     = 1'b1;
        load_type = 3'd4;
        addr      = 32'h0000_A000;
        rt_old    = 32'h0000_0055;
        @(negedge clk);
        start = 1'b0;
        check("rst_mid_read_before", {31'd0, avm_read}, 32'd1);
        check("rst_mid_busy_before", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_read_after", {31'd0, avm_read}, 32'd0);
        check("rst_mid_busy_after", {31'd0, busy}, 32'd0);
        check("rst_mid_done_after", {31'd0, done}, 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("rst_hold_done", {31'd0, done}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_done", {31'd0, done}, 32'd0);
        chk_en = 1'b1;
        run_load(1, 32'h0000_6001, 32'h0, 32'h1234_5678, 0, 32'h0000_0056, 0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
